control_sequencer: RTL and testbench

- Multi-cycle control unit and program counter for the RV32I subset core.
- Drives the register-file/ALU/data-memory datapath's control inputs and samples its Zero flag.
- Fetches from instruction memory and walks each instruction through FETCH/EXEC/(WB).
- Generates ImmExt and PCPlus4, and owns all PC update decisions.

---
 rtl/control_sequencer.sv | 230 +++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Multi-cycle RV32I-subset control unit and program counter: FETCH -> EXEC -> (WB) -> FETCH.
// Latency: ALU/lui/sw/branch/jal retire in 2 cycles, lw in 3; an unsupported encoding parks in HALT.
// No backpressure: instruction memory is combinational and the datapath accepts one step per cycle.
module control_sequencer #(
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    ADDRESS_WIDTH = 5,
  parameter logic [DATA_WIDTH-1:0] RESET_PC      = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_WIDTH-1:0]    Instr,
  input  logic                     Zero,
  output logic [DATA_WIDTH-1:0]    InstrAddr,
  output logic [ADDRESS_WIDTH-1:0] A1,
  output logic [ADDRESS_WIDTH-1:0] A2,
  output logic [ADDRESS_WIDTH-1:0] A3,
  output logic                     RegWrite,
  output logic [DATA_WIDTH-1:0]    ImmExt,
  output logic                     ALUSrc,
  output logic                     MemWrite,
  output logic [1:0]               ResultSrc,
  output logic [DATA_WIDTH-1:0]    PCPlus4,
  output logic [2:0]               ALUControl,
  output logic                     Illegal
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_WB    = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // addi x0,x0,0: a harmless instruction so the decode outputs are defined out of reset
  localparam logic [DATA_WIDTH-1:0] IR_NOP = DATA_WIDTH'(32'h0000_0013);

  state_t                  state_q;
  logic [DATA_WIDTH-1:0]   pc_q;
  logic [DATA_WIDTH-1:0]   ir_q;
  logic                    illegal_q;

  logic [6:0]              opcode;
  logic [2:0]              funct3;
  logic [6:0]              funct7;
  logic [DATA_WIDTH-1:0]   imm_i, imm_s, imm_b, imm_j, imm_u;

  logic [DATA_WIDTH-1:0]   imm_c;
  logic                    alu_src_c;
  logic [1:0]              result_src_c;
  logic [2:0]              alu_ctrl_c;
  logic                    reg_wr_c;
  logic                    mem_wr_c;
  logic                    is_lw_c;
  logic                    is_branch_c;
  logic                    is_jal_c;
  logic                    is_lui_c;
  logic                    illegal_c;

  logic                    branch_taken;
  logic [DATA_WIDTH-1:0]   pc_plus4;
  logic [DATA_WIDTH-1:0]   pc_target;
  logic [DATA_WIDTH-1:0]   exec_pc_d;

  assign opcode = ir_q[6:0];
  assign funct3 = ir_q[14:12];
  assign funct7 = ir_q[31:25];

  // Immediate formats; B and J immediates always have bit 0 clear
  assign imm_i = {{(DATA_WIDTH-12){ir_q[31]}}, ir_q[31:20]};
  assign imm_s = {{(DATA_WIDTH-12){ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign imm_b = {{(DATA_WIDTH-13){ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign imm_j = {{(DATA_WIDTH-21){ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
  assign imm_u = {ir_q[31:12], {(DATA_WIDTH-20){1'b0}}};

  // Decode the held instruction into datapath controls and a legality verdict
  always_comb begin
    imm_c        = '0;
    alu_src_c    = 1'b0;
    result_src_c = 2'b00;
    alu_ctrl_c   = ALU_ADD;
    reg_wr_c     = 1'b0;
    mem_wr_c     = 1'b0;
    is_lw_c      = 1'b0;
    is_branch_c  = 1'b0;
    is_jal_c     = 1'b0;
    is_lui_c     = 1'b0;
    illegal_c    = 1'b0;
    case (opcode)
      OP_R: begin
        reg_wr_c = 1'b1;
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000:  alu_ctrl_c = ALU_ADD;
            3'b111:  alu_ctrl_c = ALU_AND;
            3'b110:  alu_ctrl_c = ALU_OR;
            3'b010:  alu_ctrl_c = ALU_SLT;
            default: illegal_c  = 1'b1;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          alu_ctrl_c = ALU_SUB;
        end else begin
          illegal_c = 1'b1;
        end
      end
      OP_IMM: begin
        reg_wr_c  = 1'b1;
        alu_src_c = 1'b1;
        imm_c     = imm_i;
        case (funct3)
          3'b000:  alu_ctrl_c = ALU_ADD;
          3'b111:  alu_ctrl_c = ALU_AND;
          3'b110:  alu_ctrl_c = ALU_OR;
          3'b010:  alu_ctrl_c = ALU_SLT;
          default: illegal_c  = 1'b1;
        endcase
      end
      OP_LUI: begin
        // rd = 0 + U-imm through the ALU adder
        reg_wr_c  = 1'b1;
        alu_src_c = 1'b1;
        imm_c     = imm_u;
        is_lui_c  = 1'b1;
      end
      OP_LOAD: begin
        if (funct3 == 3'b010) begin
          alu_src_c    = 1'b1;
          imm_c        = imm_i;
          result_src_c = 2'b01;
          is_lw_c      = 1'b1;
        end else begin
          illegal_c = 1'b1;
        end
      end
      OP_STORE: begin
        if (funct3 == 3'b010) begin
          alu_src_c = 1'b1;
          imm_c     = imm_s;
          mem_wr_c  = 1'b1;
        end else begin
          illegal_c = 1'b1;
        end
      end
      OP_BRANCH: begin
        if (funct3 == 3'b000 || funct3 == 3'b001) begin
          alu_ctrl_c  = ALU_SUB;
          imm_c       = imm_b;
          is_branch_c = 1'b1;
        end else begin
          illegal_c = 1'b1;
        end
      end
      OP_JAL: begin
        reg_wr_c     = 1'b1;
        result_src_c = 2'b10;
        imm_c        = imm_j;
        is_jal_c     = 1'b1;
      end
      default: illegal_c = 1'b1;
    endcase
  end

  // funct3[0] separates bne from beq; all target arithmetic wraps naturally
  assign branch_taken = is_branch_c && (funct3[0] ? !Zero : Zero);
  assign pc_plus4     = pc_q + DATA_WIDTH'(4);
  assign pc_target    = pc_q + imm_c;
  assign exec_pc_d    = (branch_taken || is_jal_c) ? pc_target : pc_plus4;

  // Sequencer: state, PC, instruction register and sticky illegal flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= IR_NOP;
      illegal_q <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          ir_q    <= Instr;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          if (illegal_c) begin
            illegal_q <= 1'b1;
            state_q   <= S_HALT;
          end else if (is_lw_c) begin
            state_q <= S_WB;
          end else begin
            pc_q    <= exec_pc_d;
            state_q <= S_FETCH;
          end
        end
        S_WB: begin
          pc_q    <= pc_plus4;
          state_q <= S_FETCH;
        end
        default: state_q <= S_HALT;
      endcase
    end
  end

  assign InstrAddr  = pc_q;
  assign PCPlus4    = pc_plus4;
  assign A1         = is_lui_c ? '0 : ADDRESS_WIDTH'(ir_q[19:15]);
  assign A2         = ADDRESS_WIDTH'(ir_q[24:20]);
  assign A3         = ADDRESS_WIDTH'(ir_q[11:7]);
  assign ImmExt     = imm_c;
  assign ALUSrc     = alu_src_c;
  assign ResultSrc  = result_src_c;
  assign ALUControl = alu_ctrl_c;
  assign Illegal    = illegal_q;

  // Write strobes come only from state; rst kills them so the reset cycle never writes
  assign RegWrite = !rst && ((state_q == S_EXEC && reg_wr_c && !illegal_c) || state_q == S_WB);
  assign MemWrite = !rst && state_q == S_EXEC && mem_wr_c && !illegal_c;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: a small program in a bench-side instruction memory.
// Per-cycle expectations come from a hand-computed table; HALT and reset corners are hand-written.
// Outputs are sampled 1 time unit after the falling edge, inputs driven at the falling edge.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] Instr;
  logic        Zero;
  logic [31:0] InstrAddr;
  logic [4:0]  A1, A2, A3;
  logic        RegWrite;
  logic [31:0] ImmExt;
  logic        ALUSrc;
  logic        MemWrite;
  logic [1:0]  ResultSrc;
  logic [31:0] PCPlus4;
  logic [2:0]  ALUControl;
  logic        Illegal;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] imem [128];

  control_sequencer #(
    .DATA_WIDTH(32), .ADDRESS_WIDTH(5), .RESET_PC(32'h0000_0000)
  ) dut (
    .clk(clk), .rst(rst), .Instr(Instr), .Zero(Zero),
    .InstrAddr(InstrAddr), .A1(A1), .A2(A2), .A3(A3),
    .RegWrite(RegWrite), .ImmExt(ImmExt), .ALUSrc(ALUSrc),
    .MemWrite(MemWrite), .ResultSrc(ResultSrc), .PCPlus4(PCPlus4),
    .ALUControl(ALUControl), .Illegal(Illegal)
  );

  always #5 clk = ~clk;

  assign Instr = imem[InstrAddr[8:2]];

  typedef struct packed {
    logic        zero;
    logic [31:0] addr;
    logic [4:0]  a1;
    logic [4:0]  a3;
    logic        rw;
    logic        mw;
    logic [1:0]  rs;
    logic        src;
    logic [2:0]  alu;
    logic [31:0] imm;
    logic        ill;
  } vec_t;

  vec_t vec [27];

  function automatic vec_t mk(input logic z, input logic [31:0] ad, input logic [4:0] a1,
                              input logic [4:0] a3, input logic rw, input logic mw,
                              input logic [1:0] rs, input logic src, input logic [2:0] alu,
                              input logic [31:0] imm, input logic ill);
    vec_t v;
    v.zero = z; v.addr = ad; v.a1 = a1; v.a3 = a3; v.rw = rw; v.mw = mw;
    v.rs = rs; v.src = src; v.alu = alu; v.imm = imm; v.ill = ill;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial begin
    // Program: 00 addi x1,x0,5 / 04 addi x2,x1,-3 / 08 lw x3,8(x1) / 0C sw x2,4(x1)
    //          10 beq x1,x1,-8 / 14 bne x1,x2,+12 / 20 jal x1,+0x100 / 120 sw x2,0(x0) / 124 illegal
    for (int k = 0; k < 128; k++) imem[k] = 32'h0000_0013;
    imem[0]   = 32'h0050_0093;
    imem[1]   = 32'hFFD0_8113;
    imem[2]   = 32'h0080_A183;
    imem[3]   = 32'h0020_A223;
    imem[4]   = 32'hFE10_8CE3;
    imem[5]   = 32'h0020_9663;
    imem[8]   = 32'h1000_00EF;
    imem[72]  = 32'h0020_2023;
    imem[73]  = 32'hFFFF_FFFF;

    //             zero  addr          a1     a3     rw    mw    rs     src   alu    imm            ill
    vec[0]  = mk(1'b0, 32'h0000_0000, 5'd0,  5'd0,  1'b0, 1'b0, 2'd0, 1'b1, 3'd0, 32'h0000_0000, 1'b0);
    vec[1]  = mk(1'b0, 32'h0000_0000, 5'd0,  5'd1,  1'b1, 1'b0, 2'd0, 1'b1, 3'd0, 32'h0000_0005, 1'b0);
    vec[2]  = mk(1'b0, 32'h0000_0004, 5'd0,  5'd1,  1'b0, 1'b0, 2'd0, 1'b1, 3'd0, 32'h0000_0005, 1'b0);
    vec[3]  = mk(1'b0, 32'h0000_0004, 5'd1,  5'd2,  1'b1, 1'b0, 2'd0, 1'b1, 3'd0, 32'hFFFF_FFFD, 1'b0);
    vec[4]  = mk(1'b0, 32'h0000_0008, 5'd1,  5'd2,  1'b0, 1'b0, 2'd0, 1'b1, 3'd0, 32'hFFFF_FFFD, 1'b0);
    vec[5]  = mk(1'b0, 32'h0000_0008, 5'd1,  5'd3,  1'b0, 1'b0, 2'd1, 1'b1, 3'd0, 32'h0000_0008, 1'b0);
    vec[6]  = mk(1'b0, 32'h0000_0008, 5'd1,  5'd3,  1'b1, 1'b0, 2'd1, 1'b1, 3'd0, 32'h0000_0008, 1'b0);
    vec[7]  = mk(1'b0, 32'h0000_000C, 5'd1,  5'd3,  1'b0, 1'b0, 2'd1, 1'b1, 3'd0, 32'h0000_0008, 1'b0);
    vec[8]  = mk(1'b0, 32'h0000_000C, 5'd1,  5'd4,  1'b0, 1'b1, 2'd0, 1'b1, 3'd0, 32'h0000_0004, 1'b0);
    vec[9]  = mk(1'b0, 32'h0000_0010, 5'd1,  5'd4,  1'b0, 1'b0, 2'd0, 1'b1, 3'd0, 32'h0000_0004, 1'b0);
    vec[10] = mk(1'b1, 32'h0000_0010, 5'd1,  5'd25, 1'b0, 1'b0, 2'd0, 1'b0, 3'd1, 32'hFFFF_FFF8, 1'b0);
    vec[11] = mk(1'b0, 32'h0000_0008, 5'd1,  5'd25, 1'b0, 1'b0, 2'd0, 1'b0, 3'd1, 32'hFFFF_FFF8, 1'b0);
    vec[12] = mk(1'b0, 32'h0000_0008, 5'd1,  5'd3,  1'b0, 1'b0, 2'd1, 1'b1, 3'd0, 32'h0000_0008, 1'b0);
    vec[13] = mk(1'b0, 32'h0000_0008, 5'd1,  5'd3,  1'b1, 1'b0, 2'd1, 1'b1, 3'd0, 32'h0000_0008, 1'b0);
    vec[14] = mk(1'b0, 32'h0000_000C, 5'd1,  5'd3,  1'b0, 1'b0, 2'd1, 1'b1, 3'd0, 32'h0000_0008, 1'b0);
    vec[15] = mk(1'b0, 32'h0000_000C, 5'd1,  5'd4,  1'b0, 1'b1, 2'd0, 1'b1, 3'd0, 32'h0000_0004, 1'b0);
    vec[16] = mk(1'b0, 32'h0000_0010, 5'd1,  5'd4,  1'b0, 1'b0, 2'd0, 1'b1, 3'd0, 32'h0000_0004, 1'b0);
    vec[17] = mk(1'b0, 32'h0000_0010, 5'd1,  5'd25, 1'b0, 1'b0, 2'd0, 1'b0, 3'd1, 32'hFFFF_FFF8, 1'b0);
    vec[18] = mk(1'b0, 32'h0000_0014, 5'd1,  5'd25, 1'b0, 1'b0, 2'd0, 1'b0, 3'd1, 32'hFFFF_FFF8, 1'b0);
    vec[19] = mk(1'b0, 32'h0000_0014, 5'd1,  5'd12, 1'b0, 1'b0, 2'd0, 1'b0, 3'd1, 32'h0000_000C, 1'b0);
    vec[20] = mk(1'b0, 32'h0000_0020, 5'd1,  5'd12, 1'b0, 1'b0, 2'd0, 1'b0, 3'd1, 32'h0000_000C, 1'b0);
    vec[21] = mk(1'b0, 32'h0000_0020, 5'd0,  5'd1,  1'b1, 1'b0, 2'd2, 1'b0, 3'd0, 32'h0000_0100, 1'b0);
    vec[22] = mk(1'b0, 32'h0000_0120, 5'd0,  5'd1,  1'b0, 1'b0, 2'd2, 1'b0, 3'd0, 32'h0000_0100, 1'b0);
    vec[23] = mk(1'b0, 32'h0000_0120, 5'd0,  5'd0,  1'b0, 1'b1, 2'd0, 1'b1, 3'd0, 32'h0000_0000, 1'b0);
    vec[24] = mk(1'b0, 32'h0000_0124, 5'd0,  5'd0,  1'b0, 1'b0, 2'd0, 1'b1, 3'd0, 32'h0000_0000, 1'b0);
    vec[25] = mk(1'b0, 32'h0000_0124, 5'd31, 5'd31, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0, 32'h0000_0000, 1'b0);
    vec[26] = mk(1'b0, 32'h0000_0124, 5'd31, 5'd31, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0, 32'h0000_0000, 1'b1);

    // Reset state, observed while rst is still high (strobes must be gated)
    rst  = 1'b1;
    Zero = 1'b0;
    @(negedge clk); #1;
    chk("rst.InstrAddr", InstrAddr, 32'h0);
    chk("rst.PCPlus4",   PCPlus4,   32'h4);
    chk("rst.ImmExt",    ImmExt,    32'h0);
    chk("rst.RegWrite",  32'(RegWrite), 32'd0);
    chk("rst.MemWrite",  32'(MemWrite), 32'd0);
    chk("rst.Illegal",   32'(Illegal),  32'd0);

    // Table-driven program run, one vector per cycle
    for (int i = 0; i < 27; i++) begin
      @(negedge clk);
      rst  = 1'b0;
      Zero = vec[i].zero;
      #1;
      chk($sformatf("c%0d.InstrAddr", i+1), InstrAddr, vec[i].addr);
      chk($sformatf("c%0d.PCPlus4", i+1),   PCPlus4,   vec[i].addr + 32'd4);
      chk($sformatf("c%0d.A1", i+1),        32'(A1),   32'(vec[i].a1));
      chk($sformatf("c%0d.A3", i+1),        32'(A3),   32'(vec[i].a3));
      chk($sformatf("c%0d.RegWrite", i+1),  32'(RegWrite),   32'(vec[i].rw));
      chk($sformatf("c%0d.MemWrite", i+1),  32'(MemWrite),   32'(vec[i].mw));
      chk($sformatf("c%0d.ResultSrc", i+1), 32'(ResultSrc),  32'(vec[i].rs));
      chk($sformatf("c%0d.ALUSrc", i+1),    32'(ALUSrc),     32'(vec[i].src));
      chk($sformatf("c%0d.ALUControl", i+1), 32'(ALUControl), 32'(vec[i].alu));
      chk($sformatf("c%0d.ImmExt", i+1),    ImmExt,    vec[i].imm);
      chk($sformatf("c%0d.Illegal", i+1),   32'(Illegal),    32'(vec[i].ill));
      if (i == 10) chk("beq.A2", 32'(A2), 32'd1);
    end

    // HALT: PC frozen, strobes low, Illegal sticky for 10 cycles
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      Zero = i[0];
      #1;
      chk($sformatf("halt%0d.InstrAddr", i), InstrAddr, 32'h124);
      chk($sformatf("halt%0d.strobes", i),   32'({RegWrite, MemWrite}), 32'd0);
      chk($sformatf("halt%0d.Illegal", i),   32'(Illegal), 32'd1);
    end

    // One-cycle reset out of HALT
    @(negedge clk); rst = 1'b1; Zero = 1'b0;
    @(negedge clk); rst = 1'b0; #1;
    chk("unhalt.InstrAddr", InstrAddr, 32'h0);
    chk("unhalt.Illegal",   32'(Illegal), 32'd0);

    // Walk to lw EXEC (cycle 6 from reset) and reset there
    for (int i = 0; i < 5; i++) @(negedge clk);
    rst = 1'b1; #1;
    chk("lwrst.ResultSrc", 32'(ResultSrc), 32'd1);
    chk("lwrst.RegWrite",  32'(RegWrite),  32'd0);
    @(negedge clk); rst = 1'b0; #1;
    chk("lwrst.next.RegWrite",  32'(RegWrite), 32'd0);
    chk("lwrst.next.InstrAddr", InstrAddr, 32'h0);

    // Reset asserted in an addi EXEC cycle must suppress the write strobe
    @(negedge clk); rst = 1'b1; #1;
    chk("addirst.ImmExt",   ImmExt, 32'h5);
    chk("addirst.RegWrite", 32'(RegWrite), 32'd0);
    @(negedge clk); rst = 1'b0; #1;
    chk("addirst.next.InstrAddr", InstrAddr, 32'h0);
    chk("addirst.next.RegWrite",  32'(RegWrite), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
